// File: rtl/lns_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lns_mem_arbiter
//
// Shares one single-port synchronous memory between the instruction fetch
// stage and the data (load/store) stage of the LNS pipeline. One access is
// granted per cycle. Returned read data is steered back to the requester that
// issued the read. The grants are combinational and serve as the pipeline's
// stall condition.
//
// Arbitration: data normally wins a conflict. A starvation guard counts
// consecutive denied fetch cycles and forces fetch through once the count
// reaches MAX_WAIT. With MAX_WAIT = 0, fetch always wins.
//
// Optional build macro: LNS_ARB_STATS_EN adds three 16-bit wrapping counters
// (stat_fgrant, stat_dgrant, stat_conflict).
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   f_req/f_addr        fetch read request, held until granted
//   f_gnt               fetch granted this cycle (combinational)
//   f_rvalid/f_rdata    fetch read response; rdata holds between responses
//   d_req/d_we/d_addr/d_wdata  data request, held until granted
//   d_gnt               data granted this cycle (combinational); write done
//   d_rvalid/d_rdata    data read response; rdata holds between responses
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata           memory read data, valid the cycle after a read
//   stat_*              grant and conflict counters (LNS_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module lns_mem_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef LNS_ARB_STATS_EN
   ,
   output logic [15:0]   stat_fgrant,
   output logic [15:0]   stat_dgrant,
   output logic [15:0]   stat_conflict
`endif
);

   // The counter needs at least one bit even when MAX_WAIT is 0.
   localparam int             WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

   typedef enum logic [1:0] {
      RESP_NONE  = 2'd0,
      RESP_FETCH = 2'd1,
      RESP_DATA  = 2'd2
   } resp_sel_e;

   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   resp_sel_e      resp_sel_q, resp_sel_d;
   logic [DW-1:0]  f_rdata_q, f_rdata_d;
   logic [DW-1:0]  d_rdata_q, d_rdata_d;
   logic           f_gnt_c, d_gnt_c;

   // Grant decision; nothing is granted while reset is high.
   always_comb begin
      f_gnt_c = 1'b0;
      d_gnt_c = 1'b0;
      if (!reset) begin
         if (f_req && (!d_req || (wait_cnt_q == WAIT_MAX))) begin
            f_gnt_c = 1'b1;
         end else if (d_req) begin
            d_gnt_c = 1'b1;
         end
      end
   end

   assign f_gnt     = f_gnt_c;
   assign d_gnt     = d_gnt_c;
   assign mem_en    = f_gnt_c | d_gnt_c;
   assign mem_we    = d_gnt_c & d_we;
   assign mem_addr  = f_gnt_c ? f_addr : (d_gnt_c ? d_addr : '0);
   assign mem_wdata = d_gnt_c ? d_wdata : '0;

   // Starvation counter: counts consecutive denied fetch cycles, saturating.
   // A grant, an absent request or reset clears it.
   always_comb begin
      wait_cnt_d = '0;
      if (!reset && f_req && !f_gnt_c) begin
         wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
      end
   end

   // Owner of the read issued this cycle; writes return nothing.
   always_comb begin
      resp_sel_d = RESP_NONE;
      if (f_gnt_c) begin
         resp_sel_d = RESP_FETCH;
      end else if (d_gnt_c && !d_we) begin
         resp_sel_d = RESP_DATA;
      end
   end

   // Response cycle: mem_rdata is forwarded straight to the owner so rdata is
   // valid alongside rvalid, and the hold register keeps it afterwards.
   assign f_rvalid = !reset && (resp_sel_q == RESP_FETCH);
   assign d_rvalid = !reset && (resp_sel_q == RESP_DATA);

   always_comb begin
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
      if (f_rvalid) f_rdata_d = mem_rdata;
      if (d_rvalid) d_rdata_d = mem_rdata;
   end

   assign f_rdata = reset ? '0 : (f_rvalid ? mem_rdata : f_rdata_q);
   assign d_rdata = reset ? '0 : (d_rvalid ? mem_rdata : d_rdata_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
         resp_sel_q <= RESP_NONE;
         f_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         resp_sel_q <= resp_sel_d;
         f_rdata_q  <= f_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

`ifdef LNS_ARB_STATS_EN
   logic [15:0] stat_fgrant_q, stat_fgrant_d;
   logic [15:0] stat_dgrant_q, stat_dgrant_d;
   logic [15:0] stat_conflict_q, stat_conflict_d;

   // Counters wrap naturally at 16 bits.
   always_comb begin
      stat_fgrant_d   = stat_fgrant_q + {15'd0, f_gnt_c};
      stat_dgrant_d   = stat_dgrant_q + {15'd0, d_gnt_c};
      stat_conflict_d = stat_conflict_q + {15'd0, (f_req & d_req)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fgrant_q   <= '0;
         stat_dgrant_q   <= '0;
         stat_conflict_q <= '0;
      end else begin
         stat_fgrant_q   <= stat_fgrant_d;
         stat_dgrant_q   <= stat_dgrant_d;
         stat_conflict_q <= stat_conflict_d;
      end
   end

   assign stat_fgrant   = stat_fgrant_q;
   assign stat_dgrant   = stat_dgrant_q;
   assign stat_conflict = stat_conflict_q;
`endif

endmodule
